// File: rtl/core_mem_arb_pkg.sv
// Shared definitions for the core shared-memory arbiter.
//   DefaultAddrW / DefaultDataW : default word-address and data widths (8192 x 32-bit RAM).
//   idx_width()                  : width of a master index, never less than 1 bit.
package core_mem_arb_pkg;

  localparam int unsigned DefaultAddrW = 13;
  localparam int unsigned DefaultDataW = 32;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req_i   : request vector, one bit per master
//   last_i  : index of the most recently granted master
//   gnt_o   : one-hot grant (all zero when nothing requests)
//   idx_o   : binary index of the granted master
//   valid_o : a grant was issued
// Search starts at last_i+1 and wraps from N-1 to 0, so last_i itself is checked last.
module rr_arbiter #(
  parameter int unsigned N    = 5,
  parameter int unsigned IdxW = 3
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 1; k <= int'(N); k++) begin
      // Modular increment without a divider: last_i < N, so one subtraction suffices.
      sum = {1'b0, last_i} + (IdxW + 1)'(k);
      if (sum >= (IdxW + 1)'(N)) begin
        sum = sum - (IdxW + 1)'(N);
      end
      cand = sum[IdxW-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/core_shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between N_MASTERS Avalon-MM core ports.
// Ports:
//   clk, reset_n          : single clock, asynchronous active-low reset
//   m_address/byteenable/read/write/writedata/lock : packed per-master requests, master 0 in LSBs
//   m_waitrequest         : per-master stall (requesting and not granted)
//   m_readdata            : shared read-return bus
//   m_readdatavalid       : per-master read-return strobe, one cycle after the read grant
//   mem_*                 : single-port RAM side; mem_readdata valid one cycle after address
// Build option: define CORE_MEM_ARB_LOCK_EN to honour m_lock (bus locking); otherwise
// m_lock is ignored and no lock state exists.
module core_shared_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 5,
  parameter int unsigned ADDR_W    = DefaultAddrW,
  parameter int unsigned DATA_W    = DefaultDataW
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_byteenable,
  input  logic [N_MASTERS-1:0]          m_read,
  input  logic [N_MASTERS-1:0]          m_write,
  input  logic [N_MASTERS*DATA_W-1:0]   m_writedata,
  input  logic [N_MASTERS-1:0]          m_lock,
  output logic [N_MASTERS-1:0]          m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [N_MASTERS-1:0]          m_readdatavalid,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W/8-1:0]           mem_byteenable,
  output logic [DATA_W-1:0]             mem_writedata,
  output logic                          mem_chipselect,
  output logic                          mem_write,
  output logic                          mem_clken,
  input  logic [DATA_W-1:0]             mem_readdata
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned IdxW = idx_width(N_MASTERS);

  logic [N_MASTERS-1:0] requesting;
  logic [N_MASTERS-1:0] lock_mask;
  logic [N_MASTERS-1:0] req_elig;
  logic [N_MASTERS-1:0] gnt;
  logic [IdxW-1:0]      gnt_idx;
  logic                 gnt_valid;
  logic                 sel_write;
  logic                 sel_read;

  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic            rd_pend_q, rd_pend_d;
  logic [IdxW-1:0] rd_owner_q, rd_owner_d;

  assign requesting = m_read | m_write;

`ifdef CORE_MEM_ARB_LOCK_EN
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_owner_q, lock_owner_d;

  // While locked, only the owner may compete; an idle owner leaves the memory idle.
  always_comb begin
    lock_mask = '1;
    if (lock_q) begin
      lock_mask               = '0;
      lock_mask[lock_owner_q] = 1'b1;
    end
  end

  // Every granted transfer re-evaluates the lock: m_lock=1 takes/keeps it, m_lock=0 frees it.
  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (gnt_valid) begin
      lock_d       = m_lock[gnt_idx];
      lock_owner_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^m_lock;
  assign lock_mask   = '1;
`endif

  // Reset gates the grant so the RAM sees no access while reset_n is low.
  assign req_elig = requesting & lock_mask & {N_MASTERS{reset_n}};

  rr_arbiter #(
    .N    (N_MASTERS),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i   (req_elig),
    .last_i  (last_grant_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign m_waitrequest = requesting & ~gnt;

  // One-hot AND-OR mux of the granted master's request onto the RAM port.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (gnt[i]) begin
        mem_address    = m_address[i*ADDR_W +: ADDR_W];
        mem_byteenable = m_byteenable[i*BeW +: BeW];
        mem_writedata  = m_writedata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Read and write together is serviced as a write only.
  assign sel_write = |(gnt & m_write);
  assign sel_read  = |(gnt & m_read & ~m_write);

  assign mem_chipselect = gnt_valid;
  assign mem_write      = sel_write;
  assign mem_clken      = 1'b1;

  assign last_grant_d = gnt_valid ? gnt_idx : last_grant_q;
  assign rd_pend_d    = sel_read;
  assign rd_owner_d   = sel_read ? gnt_idx : rd_owner_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= IdxW'(N_MASTERS - 1);
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  always_comb begin
    m_readdatavalid = '0;
    if (rd_pend_q) begin
      m_readdatavalid[rd_owner_q] = 1'b1;
    end
  end

  assign m_readdata = mem_readdata;

endmodule

// File: tb/tb_core_shared_mem_arbiter.sv
module tb_core_shared_mem_arbiter;

  localparam int NM = 5;
  localparam int AW = 13;
  localparam int DW = 32;

  logic               clk;
  logic               reset_n;
  logic [NM*AW-1:0]   m_address;
  logic [NM*DW/8-1:0] m_byteenable;
  logic [NM-1:0]      m_read;
  logic [NM-1:0]      m_write;
  logic [NM*DW-1:0]   m_writedata;
  logic [NM-1:0]      m_lock;
  logic [NM-1:0]      m_waitrequest;
  logic [DW-1:0]      m_readdata;
  logic [NM-1:0]      m_readdatavalid;
  logic [AW-1:0]      mem_address;
  logic [DW/8-1:0]    mem_byteenable;
  logic [DW-1:0]      mem_writedata;
  logic               mem_chipselect;
  logic               mem_write;
  logic               mem_clken;
  logic [DW-1:0]      mem_readdata;

  int total = 0;
  int bad   = 0;

  core_shared_mem_arbiter #(
    .N_MASTERS (NM),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_lock          (m_lock),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_clken       (mem_clken),
    .mem_readdata    (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: unwritten word a holds 0x10000000+a, except 0x1FFF which starts at zero.
  logic [31:0] mem [8192];
  logic [31:0] rdq;
  logic        filled = 1'b0;
  assign mem_readdata = rdq;

  always @(posedge clk) begin
    if (!filled) begin
      for (int a = 0; a < 8192; a++) begin
        mem[a] <= (a == 8191) ? 32'h0 : 32'h1000_0000 + a;
      end
      filled <= 1'b1;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
      rdq <= mem[mem_address];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic rd, input logic wr, input logic lk,
                       input logic [12:0] a, input logic [3:0] be, input logic [31:0] wd);
    m_read[i]                = rd;
    m_write[i]               = wr;
    m_lock[i]                = lk;
    m_address[i*AW +: AW]    = a;
    m_byteenable[i*4 +: 4]   = be;
    m_writedata[i*DW +: DW]  = wd;
  endtask

  task automatic idle_all();
    m_read  = '0;
    m_write = '0;
    m_lock  = '0;
  endtask

  initial begin
    reset_n      = 1'b0;
    m_address    = '0;
    m_byteenable = '0;
    m_writedata  = '0;
    idle_all();
    tick();
    tick();

    // Reset state, with a request present
    drive(0, 1, 0, 0, 13'h010, 4'hF, 32'h0);
    #1;
    chk("rst_cs", 32'(mem_chipselect), 32'h0);
    chk("rst_we", 32'(mem_write), 32'h0);
    chk("rst_rdv", 32'(m_readdatavalid), 32'h0);
    chk("rst_clken", 32'(mem_clken), 32'h1);

    // Masters 0 and 3 read together right after reset
    drive(3, 1, 0, 0, 13'h023, 4'hF, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("t1_c1_wait", 32'(m_waitrequest), 32'h08);
    chk("t1_c1_addr", 32'(mem_address), 32'h010);
    chk("t1_c1_cs", 32'(mem_chipselect), 32'h1);
    tick();
    m_read[0] = 1'b0;
    #1;
    chk("t1_c2_wait", 32'(m_waitrequest), 32'h00);
    chk("t1_c2_addr", 32'(mem_address), 32'h023);
    chk("t1_c2_rdv", 32'(m_readdatavalid), 32'h01);
    chk("t1_c2_rdata", m_readdata, 32'h1000_0010);
    tick();
    m_read[3] = 1'b0;
    #1;
    chk("t1_c3_rdv", 32'(m_readdatavalid), 32'h08);
    chk("t1_c3_rdata", m_readdata, 32'h1000_0023);
    chk("t1_c3_cs", 32'(mem_chipselect), 32'h0);
    tick();
    chk("t1_c4_rdv", 32'(m_readdatavalid), 32'h00);

    // Reset, then all five masters read continuously: grants 0,1,2,3,4,0
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < NM; i++) drive(i, 1, 0, 0, 13'(32'h100 + i), 4'hF, 32'h0);
    for (int k = 0; k < 6; k++) begin
      int g;
      int p;
      g = k % 5;
      p = (k + 4) % 5;
      #1;
      chk($sformatf("rr%0d_wait", k), 32'(m_waitrequest), 32'h1F & ~(32'h1 << g));
      chk($sformatf("rr%0d_addr", k), 32'(mem_address), 32'h100 + g);
      if (k > 0) begin
        chk($sformatf("rr%0d_rdv", k), 32'(m_readdatavalid), 32'h1 << p);
        chk($sformatf("rr%0d_rdata", k), m_readdata, 32'h1000_0100 + p);
      end
      tick();
    end
    idle_all();
    #1;
    chk("rr_last_rdv", 32'(m_readdatavalid), 32'h01);
    chk("rr_last_rdata", m_readdata, 32'h1000_0100);
    tick();

    // Master 2 partial write then read back
    drive(2, 0, 1, 0, 13'h1FFF, 4'h3, 32'hDEAD_BEEF);
    #1;
    chk("wr_wait", 32'(m_waitrequest), 32'h0);
    chk("wr_we", 32'(mem_write), 32'h1);
    chk("wr_be", 32'(mem_byteenable), 32'h3);
    chk("wr_wd", mem_writedata, 32'hDEAD_BEEF);
    chk("wr_addr", 32'(mem_address), 32'h1FFF);
    tick();
    drive(2, 1, 0, 0, 13'h1FFF, 4'hF, 32'h0);
    #1;
    chk("rb_we", 32'(mem_write), 32'h0);
    chk("rb_cs", 32'(mem_chipselect), 32'h1);
    tick();
    idle_all();
    #1;
    chk("rb_rdv", 32'(m_readdatavalid), 32'h04);
    chk("rb_rdata", m_readdata, 32'h0000_BEEF);
    tick();

    // Master 1 read and write together: write only
    drive(1, 1, 1, 0, 13'h040, 4'hF, 32'h1234_5678);
    #1;
    chk("rw_we", 32'(mem_write), 32'h1);
    chk("rw_wait", 32'(m_waitrequest), 32'h0);
    tick();
    idle_all();
    #1;
    chk("rw_no_rdv", 32'(m_readdatavalid), 32'h0);
    tick();
    drive(1, 1, 0, 0, 13'h040, 4'hF, 32'h0);
    #1;
    tick();
    idle_all();
    #1;
    chk("rw_rb_rdv", 32'(m_readdatavalid), 32'h02);
    chk("rw_rb_rdata", m_readdata, 32'h1234_5678);
    tick();

    // Reset the cycle after a granted read: the return is dropped
    drive(0, 1, 0, 0, 13'h010, 4'hF, 32'h0);
    #1;
    chk("rd_drop_gnt", 32'(m_waitrequest), 32'h0);
    tick();
    reset_n = 1'b0;
    idle_all();
    #1;
    chk("rd_drop_rdv0", 32'(m_readdatavalid), 32'h0);
    tick();
    chk("rd_drop_rdv1", 32'(m_readdatavalid), 32'h0);
    drive(0, 1, 0, 0, 13'h011, 4'hF, 32'h0);
    drive(4, 1, 0, 0, 13'h014, 4'hF, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_first", 32'(m_waitrequest), 32'h10);
    tick();
    idle_all();
    #1;
    chk("post_rst_rdv", 32'(m_readdatavalid), 32'h01);
    chk("post_rst_rdata", m_readdata, 32'h1000_0011);
    tick();

    // Lock sequence: last grant moved to 3, then master 4 locked read / unlocked write
    drive(3, 1, 0, 0, 13'h033, 4'hF, 32'h0);
    #1;
    tick();
    idle_all();
    drive(4, 1, 0, 1, 13'h050, 4'hF, 32'h0);
    drive(0, 1, 0, 0, 13'h060, 4'hF, 32'h0);
    #1;
    chk("lk_a_wait", 32'(m_waitrequest), 32'h01);
    chk("lk_a_addr", 32'(mem_address), 32'h050);
    tick();
    drive(4, 0, 1, 0, 13'h050, 4'hF, 32'hCAFE_F00D);
    #1;
    chk("lk_b_rdv", 32'(m_readdatavalid), 32'h10);
`ifdef CORE_MEM_ARB_LOCK_EN
    chk("lk_b_wait", 32'(m_waitrequest), 32'h01);
    chk("lk_b_we", 32'(mem_write), 32'h1);
    tick();
    m_write[4] = 1'b0;
    #1;
    chk("lk_c_wait", 32'(m_waitrequest), 32'h00);
    chk("lk_c_addr", 32'(mem_address), 32'h060);
    chk("lk_c_we", 32'(mem_write), 32'h0);
    tick();
`else
    chk("lk_b_wait", 32'(m_waitrequest), 32'h10);
    chk("lk_b_addr", 32'(mem_address), 32'h060);
    chk("lk_b_we", 32'(mem_write), 32'h0);
    tick();
    #1;
    chk("lk_c_wait", 32'(m_waitrequest), 32'h01);
    chk("lk_c_addr", 32'(mem_address), 32'h050);
    chk("lk_c_we", 32'(mem_write), 32'h1);
    tick();
    m_write[4] = 1'b0;
`endif
    idle_all();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_shared_mem_arbiter.md
CORE_SHARED_MEM_ARBITER -- requirements
Module: core_shared_mem_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 5, SHALL set the number of core-side Avalon-MM ports.
REQ-002 Parameter ADDR_W, default 13, SHALL set the word-address width (8192 x 32-bit memory).
REQ-003 Parameter DATA_W, default 32, SHALL set the data width; the byteenable width SHALL be DATA_W/8.
REQ-004 clk  in  1  SHALL be the single clock for all logic and the memory.
REQ-005 reset_n  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 m_address  in  N_MASTERS*ADDR_W  per-master word address, packed, master 0 in the LSBs.
REQ-007 m_byteenable  in  N_MASTERS*DATA_W/8  per-master byte lanes.
REQ-008 m_read / m_write  in  N_MASTERS each  per-master read and write requests.
REQ-009 m_writedata  in  N_MASTERS*DATA_W  per-master write data.
REQ-010 m_lock  in  N_MASTERS  per-master lock request; present in every build.
REQ-011 m_waitrequest  out  N_MASTERS  per-master stall.
REQ-012 m_readdata  out  DATA_W  shared read-data return bus.
REQ-013 m_readdatavalid  out  N_MASTERS  per-master read-return strobe.
REQ-014 mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken  out  to single-port RAM.
REQ-015 mem_readdata  in  DATA_W  RAM output, valid one cycle after its address is presented.

Function
REQ-016 A master SHALL be requesting when m_read[i] | m_write[i].
REQ-017 At most one master SHALL be granted per cycle; grant SHALL be combinational from the current requests and the registered last_grant pointer.
REQ-018 Grant order SHALL be round-robin: first requester at index last_grant+1, ascending, wrapping N_MASTERS-1 -> 0.
REQ-019 m_waitrequest[i] SHALL equal requesting[i] & ~grant[i]; a non-requesting master SHALL see 0.
REQ-020 In the grant cycle, mem_chipselect SHALL be 1 and mem_address/byteenable/writedata SHALL carry the granted master's signals; mem_write SHALL equal m_write of the granted master.
REQ-021 With no grant: mem_chipselect=0, mem_write=0, address/data don't-care.
REQ-022 last_grant SHALL update to the granted index at the clock edge ending the grant cycle; unchanged when idle.
REQ-023 A granted read SHALL set rd_pend=1 and rd_owner=index at the edge; the next cycle m_readdatavalid[rd_owner]=1 and m_readdata=mem_readdata. Read latency is exactly 1 cycle after grant.
REQ-024 Back-to-back reads from different masters SHALL return in grant order, one per cycle, with no bubble.
REQ-025 m_read and m_write both high on one master SHALL be serviced as a write only; no readdatavalid.
REQ-026 mem_clken SHALL be constant 1.
REQ-027 Grant SHALL not depend on address; no reordering, no buffering beyond rd_pend/rd_owner.

Reset
REQ-028 On reset_n low: last_grant=N_MASTERS-1 (master 0 wins first), rd_pend=0, rd_owner=0, lock free.
REQ-029 During reset, all m_readdatavalid=0, mem_chipselect=0, mem_write=0; an in-flight read is dropped.

Configuration
REQ-030 With CORE_MEM_ARB_LOCK_EN defined: a granted transfer with m_lock[i]=1 SHALL set lock_owner=i; while locked only lock_owner SHALL be grantable, other requesters see waitrequest=1, and lock SHALL release at the edge ending a granted lock_owner transfer with m_lock=0.
REQ-031 Locked with lock_owner idle, the memory SHALL stay idle; last_grant SHALL not advance.
REQ-032 Without CORE_MEM_ARB_LOCK_EN: m_lock SHALL be ignored and no lock state synthesized.

Structure
REQ-033 Package core_mem_arb_pkg SHALL hold default ADDR_W/DATA_W constants and a clog2-based index-width function.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, last_grant in; one-hot grant, index out).

Verification
REQ-035 Reset, master 0 and 3 read simultaneously -> grant 0 cycle 1, grant 3 cycle 2; readdatavalid[0] cycle 2, [3] cycle 3.
REQ-036 All 5 masters request continuously -> grants 0,1,2,3,4,0 with no idle cycle.
REQ-037 Master 2 writes 0xDEADBEEF, byteenable 0x3, addr 0x1FFF (over 0x00000000); then reads -> 0x0000BEEF on readdatavalid[2].
REQ-038 Master 1 read + write high together -> single write, no readdatavalid[1].
REQ-039 reset_n low the cycle after a granted read -> readdatavalid stays 0; after release master 0 is first.
REQ-040 LOCK_EN: master 4 locked read then write with m_lock=0 while master 0 requests -> grants 4,4,0; without macro -> 4,0,4.
